// File: rtl/dct_mac_accumulator_if.sv
// Handshake and result bus between the transform control FSM and the MAC accumulator.
// The master drives strobes and operands; the slave returns results and block status.
interface dct_mac_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 12,
    parameter int OUT_W  = 16
);
    logic                     start;
    logic                     mac_en;
    logic                     mac_clr;
    logic signed [DATA_W-1:0] data_in;
    logic signed [COEF_W-1:0] coef_in;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic [5:0]               out_addr;
    logic                     busy;
    logic                     done;
    logic                     sat_flag;

    modport master (
        output start, mac_en, mac_clr, data_in, coef_in,
        input  out_valid, out_data, out_addr, busy, done, sat_flag
    );

    modport slave (
        input  start, mac_en, mac_clr, data_in, coef_in,
        output out_valid, out_data, out_addr, busy, done, sat_flag
    );
endinterface

// File: rtl/dct_mac_accumulator.sv
// Two-stage multiply-accumulate for an 8x8 transform: 64 products per output point,
// then round, scale and saturate each sum and emit it with its 6-bit result index.
module dct_mac_accumulator #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 12,
    parameter int ACC_W  = 26,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    dct_mac_accumulator_if.slave bus
);
    localparam int PROD_W = DATA_W + COEF_W;
    // Half-LSB rounding bias; collapses to zero when SHIFT is 0.
    localparam logic signed [ACC_W:0] BIAS = ((ACC_W+1)'(1) << SHIFT) >> 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [5:0]                term_q, term_d;
    logic [5:0]                idx_q, idx_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic                      p1v_q, p1v_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]   out_data_q, out_data_d;
    logic [5:0]                out_addr_q, out_addr_d;
    logic                      sat_q, sat_d;

    logic signed [PROD_W-1:0]  prod_w;
    logic signed [ACC_W-1:0]   full_w;
    logic signed [ACC_W:0]     biased_w;
    logic signed [ACC_W:0]     scaled_w;
    logic                      fits_w;
    logic signed [OUT_W-1:0]   clamped_w;

    assign prod_w   = PROD_W'(bus.data_in) * PROD_W'(bus.coef_in);
    assign full_w   = acc_q + ACC_W'(prod_q);
    assign biased_w = (ACC_W+1)'(full_w) + BIAS;
    assign scaled_w = biased_w >>> SHIFT;
    // Result fits when every bit above the output sign bit matches it.
    assign fits_w   = (scaled_w[ACC_W:OUT_W-1] == '0) || (scaled_w[ACC_W:OUT_W-1] == '1);
    assign clamped_w = fits_w ? OUT_W'(scaled_w)
                     : (scaled_w[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        term_d      = term_q;
        idx_d       = idx_q;
        prod_d      = prod_q;
        p1v_d       = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        sat_d       = sat_q;

        case (state_q)
            RUN: begin
                p1v_d = bus.mac_en && !bus.mac_clr;
                if (bus.mac_en) prod_d = prod_w;
                if (bus.mac_clr) begin
                    acc_d  = '0;
                    term_d = '0;
                end else if (p1v_q) begin
                    term_d = term_q + 6'd1;
                    if (term_q == 6'd63) begin
                        acc_d       = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = clamped_w;
                        out_addr_d  = idx_q;
                        sat_d       = sat_q | ~fits_w;
                        idx_d       = idx_q + 6'd1;
                        // Last point of the block: anything still in stage 1 is dropped.
                        if (idx_q == 6'd63) begin
                            state_d = DONE;
                            p1v_d   = 1'b0;
                        end
                    end else begin
                        acc_d = full_w;
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    state_d = RUN;
                    acc_d   = '0;
                    term_d  = '0;
                    idx_d   = '0;
                    sat_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            term_q      <= '0;
            idx_q       <= '0;
            prod_q      <= '0;
            p1v_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            term_q      <= term_d;
            idx_q       <= idx_d;
            prod_q      <= prod_d;
            p1v_q       <= p1v_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.sat_flag  = sat_q;
endmodule
